// File: rtl/ring_sequence_monitor.sv
// Monitors a right-shifting one-hot ring counter: encodes its phase, counts
// revolutions and latches the first sequencing fault until cleared.
module ring_sequence_monitor #(
    parameter int N  = 8,
    parameter int PW = $clog2(N),
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  ring,
    input  logic          en,
    input  logic          clr,
    output logic [PW-1:0] phase,
    output logic          valid,
    output logic          wrap,
    output logic          resync,
    output logic [CW-1:0] rev_count,
    output logic          err,
    output logic [1:0]    err_code
);

    localparam logic [1:0] S_SYNC  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    localparam logic [N-1:0] TOP = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    localparam logic [1:0] E_NONE   = 2'b00;
    localparam logic [1:0] E_ONEHOT = 2'b01;
    localparam logic [1:0] E_STEP   = 2'b10;

    logic [1:0]    state, state_d;
    logic [N-1:0]  prev, prev_d;
    logic [N-1:0]  exp_ring;
    logic          onehot;
    logic [PW-1:0] enc;

    logic [PW-1:0] phase_d;
    logic [CW-1:0] rev_d;
    logic          err_d, wrap_d, resync_d;
    logic [1:0]    code_d;

    assign exp_ring = (prev == ONE) ? TOP : (prev >> 1);
    assign onehot   = (ring != '0) && ((ring & (ring - ONE)) == '0);

    // MSB maps to phase 0, LSB to phase N-1
    always_comb begin
        enc = '0;
        for (int i = 0; i < N; i++)
            if (ring[i]) enc = PW'(N - 1 - i);
    end

    always_comb begin
        state_d  = state;
        prev_d   = prev;
        phase_d  = phase;
        rev_d    = rev_count;
        err_d    = err;
        code_d   = err_code;
        wrap_d   = 1'b0;
        resync_d = 1'b0;
        case (state)
            S_SYNC: begin
                if (clr) rev_d = '0;
                if (ring == TOP) begin
                    state_d = S_TRACK;
                    phase_d = '0;
                    prev_d  = ring;
                end
            end
            S_TRACK: begin
                // clr zeroes the count first, so a coincident wrap lands on 1
                if (clr) rev_d = '0;
                if (ring == exp_ring) begin
                    phase_d = enc;
                    prev_d  = ring;
                    if (prev == ONE) begin
                        wrap_d = 1'b1;
                        rev_d  = rev_d + CW'(1);
                    end
                end else if (ring == TOP) begin
                    // upstream restarted mid-revolution: follow it, not a fault
                    phase_d  = '0;
                    prev_d   = ring;
                    resync_d = 1'b1;
                end else begin
                    state_d = S_FAULT;
                    if (!err) begin
                        err_d  = 1'b1;
                        code_d = onehot ? E_STEP : E_ONEHOT;
                    end
                end
            end
            S_FAULT: begin
                if (clr) begin
                    state_d = S_SYNC;
                    err_d   = 1'b0;
                    code_d  = E_NONE;
                    rev_d   = '0;
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_SYNC;
            prev      <= '0;
            phase     <= '0;
            valid     <= 1'b0;
            wrap      <= 1'b0;
            resync    <= 1'b0;
            rev_count <= '0;
            err       <= 1'b0;
            err_code  <= E_NONE;
        end else if (en) begin
            state     <= state_d;
            prev      <= prev_d;
            phase     <= phase_d;
            valid     <= (state_d == S_TRACK);
            wrap      <= wrap_d;
            resync    <= resync_d;
            rev_count <= rev_d;
            err       <= err_d;
            err_code  <= code_d;
        end else begin
            wrap      <= 1'b0;
            resync    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ring_sequence_monitor.sv
// Self-checking bench: directed table, hand-built corner sequences and
// randomized ring traffic compared against a position-based reference model.
module tb_ring_sequence_monitor;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] ring = 8'h00;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] phase;
    logic       valid, wrap, resync, err;
    logic [7:0] rev_count;
    logic [1:0] err_code;

    int errors = 0;
    int checks = 0;

    ring_sequence_monitor #(.N(N), .PW(3), .CW(8)) dut (
        .clk(clk), .rstn(rstn), .ring(ring), .en(en), .clr(clr),
        .phase(phase), .valid(valid), .wrap(wrap), .resync(resync),
        .rev_count(rev_count), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Reference model: tracks position in the revolution, not a shift register
    int m_st;  // 0 sync, 1 track, 2 fault
    int m_pos, m_rev, m_err, m_code, m_wrap, m_resync;

    task automatic model_reset();
        m_st = 0; m_pos = 0; m_rev = 0; m_err = 0; m_code = 0; m_wrap = 0; m_resync = 0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic e, input logic c);
        logic [7:0] nxt;
        m_wrap = 0; m_resync = 0;
        if (!e) return;
        nxt = 8'h80;
        nxt = nxt >> ((m_pos + 1) % N);
        case (m_st)
            0: begin
                if (c) m_rev = 0;
                if (r == 8'h80) begin m_st = 1; m_pos = 0; end
            end
            1: begin
                if (c) m_rev = 0;
                if (r == nxt) begin
                    m_pos = (m_pos + 1) % N;
                    if (m_pos == 0) begin m_wrap = 1; m_rev = (m_rev + 1) % 256; end
                end else if (r == 8'h80) begin
                    m_pos = 0; m_resync = 1;
                end else begin
                    m_st = 2;
                    if (m_err == 0) begin
                        m_err = 1;
                        m_code = ($countones(r) == 1) ? 2 : 1;
                    end
                end
            end
            default: begin
                if (c) begin m_st = 0; m_err = 0; m_code = 0; m_rev = 0; end
            end
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic cmp_model();
        chk("phase", {29'd0, phase}, m_pos);
        chk("valid", {31'd0, valid}, (m_st == 1) ? 1 : 0);
        chk("wrap", {31'd0, wrap}, m_wrap);
        chk("resync", {31'd0, resync}, m_resync);
        chk("rev_count", {24'd0, rev_count}, m_rev);
        chk("err", {31'd0, err}, m_err);
        chk("err_code", {30'd0, err_code}, m_code);
    endtask

    task automatic step(input logic [7:0] r, input logic e, input logic c);
        ring = r; en = e; clr = c;
        @(posedge clk);
        #1;
        model_step(r, e, c);
        cmp_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; en = 1'b0; clr = 1'b0; ring = 8'h00;
        #2;
        model_reset();
        cmp_model();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // advance from the current legal value through k more legal values
    task automatic run_legal(inout logic [7:0] r, input int k);
        for (int i = 0; i < k; i++) begin
            r = (r == 8'h01) ? 8'h80 : (r >> 1);
            step(r, 1'b1, 1'b0);
        end
    endtask

    typedef struct {
        logic [7:0] ring;
        logic [2:0] phase;
        logic       valid;
        logic       wrap;
        logic [7:0] rev;
        logic       err;
        logic [1:0] code;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic [7:0] r;
        logic [7:0] ur;

        for (int i = 0; i < 20; i++) begin
            tbl[i].ring  = 8'h80 >> (i % 8);
            tbl[i].phase = 3'(i % 8);
            tbl[i].valid = 1'b1;
            tbl[i].wrap  = (i > 0) && (i % 8 == 0);
            tbl[i].rev   = 8'(i / 8);
            tbl[i].err   = 1'b0;
            tbl[i].code  = 2'b00;
        end

        // normal run straight out of reset
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].ring, 1'b1, 1'b0);
            chk("tbl_phase", {29'd0, phase}, {29'd0, tbl[i].phase});
            chk("tbl_valid", {31'd0, valid}, {31'd0, tbl[i].valid});
            chk("tbl_wrap", {31'd0, wrap}, {31'd0, tbl[i].wrap});
            chk("tbl_rev", {24'd0, rev_count}, {24'd0, tbl[i].rev});
            chk("tbl_err", {29'd0, err, err_code}, {29'd0, tbl[i].err, tbl[i].code});
        end

        // zeros in SYNC are not a fault
        do_reset();
        for (int i = 0; i < 5; i++) step(8'h00, 1'b1, 1'b0);
        chk("sync_zero_err", {31'd0, err}, 0);
        chk("sync_zero_valid", {31'd0, valid}, 0);
        step(8'h80, 1'b1, 1'b0);
        chk("sync_lock_valid", {31'd0, valid}, 1);

        // non-one-hot at phase 3, then code stays sticky
        r = 8'h80;
        run_legal(r, 3);
        chk("pre_fault_phase", {29'd0, phase}, 3);
        step(8'h14, 1'b1, 1'b0);
        chk("onehot_code", {30'd0, err_code}, 1);
        chk("onehot_valid", {31'd0, valid}, 0);
        chk("onehot_phase", {29'd0, phase}, 3);
        step(8'h00, 1'b1, 1'b0);
        chk("sticky_code", {30'd0, err_code}, 1);

        // skipped step, clear, relock
        do_reset();
        step(8'h80, 1'b1, 1'b0);
        step(8'h40, 1'b1, 1'b0);
        step(8'h20, 1'b1, 1'b0);
        step(8'h08, 1'b1, 1'b0);
        chk("skip_code", {30'd0, err_code}, 2);
        step(8'h04, 1'b1, 1'b1);
        chk("clr_err", {31'd0, err}, 0);
        chk("clr_rev", {24'd0, rev_count}, 0);
        chk("clr_valid", {31'd0, valid}, 0);
        step(8'h80, 1'b1, 1'b0);
        chk("relock_valid", {31'd0, valid}, 1);

        // upstream restart at phase 5
        do_reset();
        step(8'h80, 1'b1, 1'b0);
        r = 8'h80;
        run_legal(r, 13);
        chk("pre_resync_phase", {29'd0, phase}, 5);
        step(8'h80, 1'b1, 1'b0);
        chk("resync_pulse", {31'd0, resync}, 1);
        chk("resync_phase", {29'd0, phase}, 0);
        chk("resync_rev", {24'd0, rev_count}, 1);
        chk("resync_err", {31'd0, err}, 0);
        step(8'h40, 1'b1, 1'b0);
        chk("resync_one_cycle", {31'd0, resync}, 0);

        // enable low freezes everything, then resume and clr with a wrap
        for (int i = 0; i < 4; i++) begin
            step(8'h40, 1'b0, 1'b0);
            chk("frozen_phase", {29'd0, phase}, 1);
        end
        r = 8'h40;
        run_legal(r, 6);
        chk("reenable_err", {31'd0, err}, 0);
        step(8'h80, 1'b1, 1'b1);
        chk("clr_wrap_pulse", {31'd0, wrap}, 1);
        chk("clr_wrap_rev", {24'd0, rev_count}, 1);

        // counter rollover
        do_reset();
        step(8'h80, 1'b1, 1'b0);
        r = 8'h80;
        run_legal(r, 255 * 8);
        chk("rev_255", {24'd0, rev_count}, 255);
        run_legal(r, 8);
        chk("rollover_rev", {24'd0, rev_count}, 0);
        chk("rollover_wrap", {31'd0, wrap}, 1);

        // async reset while a pulse is high
        #1;
        rstn = 1'b0;
        #1;
        model_reset();
        chk("reset_kills_wrap", {31'd0, wrap}, 0);
        cmp_model();
        @(negedge clk);
        rstn = 1'b1;
        step(8'h00, 1'b1, 1'b0);
        chk("no_pulse_after_reset", {31'd0, wrap}, 0);

        // randomized traffic
        do_reset();
        ur = 8'h80;
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 75)      ur = (ur == 8'h01) ? 8'h80 : (ur >> 1);
            else if (sel < 82) ur = 8'h80;
            else if (sel < 88) ur = 8'h01 << $urandom_range(0, 7);
            else if (sel < 94) ur = 8'($urandom);
            step(ur, ($urandom_range(0, 9) != 0), ($urandom_range(0, 24) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
